// File: rtl/reg_file.sv
// Integer register file for the single-cycle RISC-V core: two combinational read ports,
// one write-back port, and a handshaked dump port that streams a snapshot of every register.
module reg_file #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    localparam int AW  = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            RegWrite,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    input  logic [AW-1:0]   rd,
    input  logic [XLEN-1:0] wd,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            dump_req,
    output logic            dump_valid,
    input  logic            dump_ready,
    output logic [AW-1:0]   dump_idx,
    output logic [XLEN-1:0] dump_data,
    output logic            dump_busy,
    output logic            dump_done
);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } dump_state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

    // x0 has no storage; it reads as zero through the read-port logic.
    logic [XLEN-1:0] regs [1:NREG-1];
    dump_state_t     state;
    logic [AW-1:0]   next_idx;

    assign next_idx = dump_idx + AW'(1);

    // NOTE: the array is architecturally reset to zero, so every entry is cleared here;
    // a register file without a defined reset value would leave this loop out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (RegWrite && rd != '0) begin
            regs[rd] <= wd;
        end
    end

    // NOTE: every output gets a value before any condition, so no latch is inferred.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (rs1 != '0) begin
            rd1 = (RegWrite && rd == rs1) ? wd : regs[rs1];
        end
        if (rs2 != '0) begin
            rd2 = (RegWrite && rd == rs2) ? wd : regs[rs2];
        end
    end

    // NOTE: non-blocking assignments make regs[next_idx] the value from before any
    // write landing on the same edge, which is exactly the snapshot the dump needs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            dump_valid <= 1'b0;
            dump_idx   <= '0;
            dump_data  <= '0;
            dump_busy  <= 1'b0;
            dump_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (dump_req) begin
                        state      <= SEND;
                        dump_valid <= 1'b1;
                        dump_busy  <= 1'b1;
                        dump_idx   <= '0;
                        dump_data  <= '0;
                    end
                end
                SEND: begin
                    // Without dump_ready the beat simply holds, regardless of core writes.
                    if (dump_ready) begin
                        if (dump_idx == LAST_IDX) begin
                            state      <= DONE;
                            dump_valid <= 1'b0;
                            dump_done  <= 1'b1;
                        end else begin
                            dump_idx  <= next_idx;
                            dump_data <= regs[next_idx];
                        end
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    dump_done <= 1'b0;
                    dump_busy <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    dump_valid <= 1'b0;
                    dump_busy  <= 1'b0;
                    dump_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: stimulus pushes expectations from an array-level model,
// a negedge monitor pops and compares reads, dump beats and dump status flags.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RegWrite;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] wd;
    logic [31:0] rd1, rd2;
    logic        dump_req, dump_valid, dump_ready, dump_busy, dump_done;
    logic [4:0]  dump_idx;
    logic [31:0] dump_data;

    reg_file #(.XLEN(32), .NREG(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .RegWrite   (RegWrite),
        .rs1        (rs1),
        .rs2        (rs2),
        .rd         (rd),
        .wd         (wd),
        .rd1        (rd1),
        .rd2        (rd2),
        .dump_req   (dump_req),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_idx   (dump_idx),
        .dump_data  (dump_data),
        .dump_busy  (dump_busy),
        .dump_done  (dump_done)
    );

    always #5 clk = ~clk;

    typedef struct {logic [31:0] a; logic [31:0] b;} rd_exp_t;
    typedef struct {logic [4:0] idx; logic [31:0] data;} beat_t;
    typedef struct {logic valid; logic busy; logic done;} stat_t;

    rd_exp_t rd_q[$];
    beat_t   dump_q[$];
    stat_t   st_q[$];

    // Reference model: architectural registers plus "which beat is on offer".
    logic [31:0] mregs [32];
    int          m_beat;   // -1 when no dump is streaming
    bit          m_done;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (RegWrite && rd == a) return wd;
        return mregs[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        m_beat = -1;
        m_done = 1'b0;
        dump_q.delete();
    endtask

    // Model of one rising edge: dump progress reads the pre-write register values.
    task automatic model_edge();
        beat_t b;
        if (m_done) begin
            m_done = 1'b0;
        end else if (m_beat >= 0) begin
            if (dump_ready) begin
                if (m_beat < 31) begin
                    m_beat = m_beat + 1;
                    b.idx  = 5'(m_beat);
                    b.data = mregs[m_beat];
                    dump_q.push_back(b);
                end else begin
                    m_beat = -1;
                    m_done = 1'b1;
                end
            end
        end else if (dump_req) begin
            m_beat = 0;
            b.idx  = 5'd0;
            b.data = 32'd0;
            dump_q.push_back(b);
        end
        if (RegWrite && rd != 5'd0) mregs[rd] = wd;
    endtask

    // Drive one cycle of inputs (just after a rising edge), queue expectations, take the edge.
    task automatic apply(input bit rw, input logic [4:0] a_rd, input logic [31:0] a_wd,
                         input logic [4:0] a1, input logic [4:0] a2, input bit req, input bit rdy);
        rd_exp_t e;
        stat_t   s;
        RegWrite   = rw;
        rd         = a_rd;
        wd         = a_wd;
        rs1        = a1;
        rs2        = a2;
        dump_req   = req;
        dump_ready = rdy;
        e.a = exp_read(a1);
        e.b = exp_read(a2);
        rd_q.push_back(e);
        s.valid = (m_beat >= 0);
        s.busy  = (m_beat >= 0) || m_done;
        s.done  = m_done;
        st_q.push_back(s);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        RegWrite = 1'b0;
        dump_req = 1'b0;
        #1;
        check("rst_dump_valid", {31'd0, dump_valid}, 32'd0);
        check("rst_dump_busy",  {31'd0, dump_busy},  32'd0);
        check("rst_dump_done",  {31'd0, dump_done},  32'd0);
        check("rst_dump_idx",   {27'd0, dump_idx},   32'd0);
        check("rst_dump_data",  dump_data,           32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && (m_beat >= 0 || m_done); k++) begin
            apply(1'b0, 5'd0, 32'd0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'b0, 1'b1);
        end
    endtask

    // Monitor: reads every cycle, status flags every cycle, a beat whenever dump_valid is high.
    initial begin
        rd_exp_t e;
        stat_t   s;
        beat_t   b;
        forever begin
            @(negedge clk);
            if (rd_q.size() > 0) begin
                e = rd_q.pop_front();
                check("rd1", rd1, e.a);
                check("rd2", rd2, e.b);
            end
            if (st_q.size() > 0) begin
                s = st_q.pop_front();
                check("dump_valid", {31'd0, dump_valid}, {31'd0, s.valid});
                check("dump_busy",  {31'd0, dump_busy},  {31'd0, s.busy});
                check("dump_done",  {31'd0, dump_done},  {31'd0, s.done});
            end
            if (rst_n && dump_valid) begin
                if (dump_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL dump_beat: unexpected beat idx %0d, none expected", dump_idx);
                end else begin
                    b = dump_q[0];
                    check("dump_idx",  {27'd0, dump_idx}, {27'd0, b.idx});
                    check("dump_data", dump_data, b.data);
                    if (dump_ready) void'(dump_q.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish, %0d miscompares so far", n_err);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        RegWrite = 1'b0; rd = '0; wd = '0; rs1 = '0; rs2 = '0;
        dump_req = 1'b0; dump_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Random traffic with a dump in flight, then reset mid-run and read everything back.
        for (int i = 0; i < 20; i++) begin
            apply(1'b1, 5'($urandom_range(0, 31)), $urandom, 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)), (i == 5), 1'b1);
        end
        do_reset();
        for (int i = 0; i < 32; i++) apply(1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i), 1'b0, 1'b0);

        // Write x5, then attempt x0.
        apply(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 1'b0, 1'b0);
        apply(1'b1, 5'd0, 32'h12345678, 5'd5, 5'd0, 1'b0, 1'b0);
        apply(1'b0, 5'd0, 32'd0, 5'd0, 5'd5, 1'b0, 1'b0);

        // Same-cycle bypass, then the committed value.
        apply(1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd7, 1'b0, 1'b0);
        apply(1'b0, 5'd0, 32'd0, 5'd7, 5'd7, 1'b0, 1'b0);

        // Preload i*0x01010101 and dump with dump_ready tied high.
        for (int i = 1; i < 32; i++) apply(1'b1, 5'(i), i * 32'h01010101, 5'(i), 5'd0, 1'b0, 1'b0);
        apply(1'b0, 5'd0, 32'd0, 5'd1, 5'd2, 1'b1, 1'b1);
        drain();
        apply(1'b0, 5'd0, 32'd0, 5'd3, 5'd4, 1'b0, 1'b1);

        // Backpressure at idx 3 while x3 is overwritten.
        apply(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) apply(1'b0, 5'd0, 32'd0, 5'd3, 5'd0, 1'b0, 1'b1);
        apply(1'b1, 5'd3, 32'hFFFFFFFF, 5'd3, 5'd3, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) apply(1'b0, 5'd0, 32'd0, 5'd3, 5'd0, 1'b0, 1'b0);
        drain();
        apply(1'b0, 5'd0, 32'd0, 5'd3, 5'd0, 1'b0, 1'b1);

        // Ignored second request at idx 10, reset at idx 20, then a fresh dump.
        apply(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 1'b1);
        for (int k = 0; k < 40 && m_beat != 20; k++) begin
            apply(1'b0, 5'd0, 32'd0, 5'd10, 5'd20, (m_beat == 10), 1'b1);
        end
        check("reached_idx20", {27'd0, dump_idx}, 32'd20);
        do_reset();
        for (int i = 1; i < 6; i++) apply(1'b1, 5'(i * 3), $urandom, 5'(i), 5'(i * 3), 1'b0, 1'b0);
        apply(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 1'b1);
        drain();

        // Random phase: writes during dumps, random backpressure and requests.
        for (int i = 0; i < 300; i++) begin
            apply(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0));
        end
        drain();
        apply(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
